// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory request/acknowledge bus between the memory access unit and the
// data memory.
//   dmem_req    master->slave  request valid
//   dmem_we     master->slave  1 = store, 0 = load; valid while dmem_req
//   dmem_addr   master->slave  request address
//   dmem_wdata  master->slave  store data
//   dmem_rdata  slave->master  load return data, valid with dmem_ack
//   dmem_ack    slave->master  request accepted/completed this cycle
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int unsigned register_width = 32
) ();
    logic                      dmem_req;
    logic                      dmem_we;
    logic [register_width-1:0] dmem_addr;
    logic [register_width-1:0] dmem_wdata;
    logic [register_width-1:0] dmem_rdata;
    logic                      dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Single-port data-memory sequencer. Takes the oldest load/store entry from the
// buffer stage, issues it on the dmem bus, and reports retirement upstream.
// Supports flush (in-flight access drained silently) and a bounded wait.
//   clk, rst        clock / asynchronous active-high reset
//   i_mem_addr      load/store address from buffer stage
//   i_mem_data      store data from buffer stage
//   i_load_flag     oldest entry is a load (held until o_mem_in_done)
//   i_store_flag    oldest entry is a store (held until o_mem_in_done)
//   i_flush_en      branch flush, abandon current access
//   o_mem_in_done   1-cycle retire pulse
//   o_load_data     last completed load value
//   o_mem_err       1-cycle pulse with o_mem_in_done on timeout
//   io_dmem         data-memory bus (master side)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned register_width = 32,
    parameter int unsigned timeout        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [register_width-1:0] i_mem_addr,
    input  logic [register_width-1:0] i_mem_data,
    input  logic                      i_load_flag,
    input  logic                      i_store_flag,
    input  logic                      i_flush_en,
    output logic                      o_mem_in_done,
    output logic [register_width-1:0] o_load_data,
    output logic                      o_mem_err,
    mem_access_unit_if.master         io_dmem
);

    localparam int unsigned cnt_w = $clog2(timeout + 1);
    localparam logic [cnt_w-1:0] LimitCnt = cnt_w'(timeout - 1);
    localparam logic [cnt_w-1:0] MaxCnt   = cnt_w'(timeout);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StDone  = 2'd2,
        StDrain = 2'd3
    } state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [cnt_w-1:0]          r_cnt;
    logic                      r_we;
    logic                      r_err;
    logic [register_width-1:0] r_addr;
    logic [register_width-1:0] r_wdata;
    logic [register_width-1:0] r_load_data;

    logic w_start;
    logic w_hit_limit;
    logic w_drain_expire;
    logic w_abort;

    assign w_start     = (i_load_flag | i_store_flag) & ~i_flush_en;
    assign w_hit_limit = (r_cnt == LimitCnt);
    // A flush on the last REQ cycle pushes the counter past the limit, so
    // DRAIN uses >= to still terminate.
    assign w_drain_expire = (r_cnt >= LimitCnt);
    assign w_abort        = ~io_dmem.dmem_ack & ~i_flush_en & w_hit_limit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = StReq;
                end
            end
            StReq: begin
                if (io_dmem.dmem_ack) begin
                    w_state_next = i_flush_en ? StIdle : StDone;
                end else if (i_flush_en) begin
                    w_state_next = StDrain;
                end else if (w_hit_limit) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            StDrain: begin
                if (io_dmem.dmem_ack || w_drain_expire) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output decode of registered state
    always_comb begin
        io_dmem.dmem_req = (r_state == StReq) || (r_state == StDrain);
        o_mem_in_done    = (r_state == StDone);
        o_mem_err        = (r_state == StDone) && r_err;
    end

    // Request capture, wait counter and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_load_data <= '0;
        end else begin
            // Only meaningful on the cycle after REQ, i.e. while in DONE.
            r_err <= (r_state == StReq) && w_abort;
            if (r_state == StIdle) begin
                if (w_start) begin
                    r_addr  <= i_mem_addr;
                    r_wdata <= i_mem_data;
                    r_we    <= i_store_flag;
                    r_cnt   <= '0;
                end
            end
            if ((r_state == StReq) || (r_state == StDrain)) begin
                if (!io_dmem.dmem_ack && (r_cnt != MaxCnt)) begin
                    r_cnt <= r_cnt + cnt_w'(1);
                end
            end
            if (r_state == StReq) begin
                if (io_dmem.dmem_ack && !i_flush_en && !r_we) begin
                    r_load_data <= io_dmem.dmem_rdata;
                end else if (w_abort) begin
                    r_load_data <= '0;
                end
            end
        end
    end

    assign io_dmem.dmem_we    = r_we;
    assign io_dmem.dmem_addr  = r_addr;
    assign io_dmem.dmem_wdata = r_wdata;
    assign o_load_data        = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int W  = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_mem_addr;
    logic [W-1:0] i_mem_data;
    logic         i_load_flag;
    logic         i_store_flag;
    logic         i_flush_en;
    logic         o_mem_in_done;
    logic [W-1:0] o_load_data;
    logic         o_mem_err;

    mem_access_unit_if #(.register_width(W)) dmem ();

    mem_access_unit #(
        .register_width(W),
        .timeout       (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mem_addr   (i_mem_addr),
        .i_mem_data   (i_mem_data),
        .i_load_flag  (i_load_flag),
        .i_store_flag (i_store_flag),
        .i_flush_en   (i_flush_en),
        .o_mem_in_done(o_mem_in_done),
        .o_load_data  (o_load_data),
        .o_mem_err    (o_mem_err),
        .io_dmem      (dmem)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_load_data;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        i_mem_addr = '0; i_mem_data = '0;
        i_load_flag = 1'b0; i_store_flag = 1'b0; i_flush_en = 1'b0;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
        #2;
        checks++;
        if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata,
             o_mem_in_done, o_mem_err, o_load_data} !== '0) begin
            failures++;
            $display("FAIL reset_async: outputs not all zero req=%b we=%b addr=%h done=%b ld=%h",
                     dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, o_mem_in_done, o_load_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_load_data = '0;
        @(negedge clk);
        checks++;
        if ({dmem.dmem_req, o_mem_in_done, o_load_data} !== '0) begin
            failures++;
            $display("FAIL reset_idle: req=%b done=%b load_data=%h expected all 0",
                     dmem.dmem_req, o_mem_in_done, o_load_data);
        end
    endtask

    // One access from IDLE (or straight after a DONE when chained). Memory acks
    // in REQ cycle number ack_delay; ack_delay >= TO means never.
    task automatic run_access(input logic ld, input logic st, input logic [W-1:0] addr,
                              input logic [W-1:0] data, input int ack_delay,
                              input logic [W-1:0] rdata, input int exp_lat,
                              input bit drop_after, input string name);
        int   lat;
        int   reqc;
        int   exp_reqc;
        bit   timed_out;
        i_load_flag  = ld;
        i_store_flag = st;
        i_mem_addr   = addr;
        i_mem_data   = data;
        timed_out    = (ack_delay >= TO);
        exp_reqc     = timed_out ? TO : ack_delay + 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (dmem.dmem_req !== 1'b1 && lat < 8);
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, exp_lat);
        end
        reqc = 0;
        while (dmem.dmem_req === 1'b1 && reqc < TO + 4) begin
            checks++;
            if ({dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, o_mem_in_done} !==
                {st, addr, data, 1'b0}) begin
                failures++;
                $display("FAIL %s req_fields: we=%b addr=%h wdata=%h done=%b expected %b %h %h 0",
                         name, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, o_mem_in_done,
                         st, addr, data);
            end
            dmem.dmem_ack   = (reqc == ack_delay);
            dmem.dmem_rdata = (reqc == ack_delay) ? rdata : W'($urandom());
            reqc++;
            @(negedge clk);
        end
        dmem.dmem_ack = 1'b0;
        checks++;
        if (reqc != exp_reqc) begin
            failures++;
            $display("FAIL %s req_cycles: got %0d expected %0d", name, reqc, exp_reqc);
        end
        if (timed_out) begin
            exp_load_data = '0;
        end else if (ld && !st) begin
            exp_load_data = rdata;
        end
        checks++;
        if ({o_mem_in_done, o_mem_err} !== {1'b1, timed_out}) begin
            failures++;
            $display("FAIL %s done_err: got done=%b err=%b expected 1 %b",
                     name, o_mem_in_done, o_mem_err, timed_out);
        end
        checks++;
        if (o_load_data !== exp_load_data) begin
            failures++;
            $display("FAIL %s load_data: got %h expected %h", name, o_load_data, exp_load_data);
        end
        if (drop_after) begin
            i_load_flag  = 1'b0;
            i_store_flag = 1'b0;
            @(negedge clk);
            checks++;
            if ({o_mem_in_done, o_mem_err, dmem.dmem_req} !== 3'b000) begin
                failures++;
                $display("FAIL %s single_pulse: done=%b err=%b req=%b expected 000",
                         name, o_mem_in_done, o_mem_err, dmem.dmem_req);
            end
        end
    endtask

    // Load flushed in REQ cycle f. a = drain cycle of the ack, -1 = ack together
    // with the flush, -2 = no ack at all (drain times out).
    task automatic test_flush(input int f, input int a, input string name);
        logic [W-1:0] prev;
        int k;
        int total;
        int dones;
        int exp_total;
        prev = exp_load_data;
        i_load_flag  = 1'b1;
        i_store_flag = 1'b0;
        i_mem_addr   = W'($urandom());
        i_mem_data   = W'($urandom());
        @(negedge clk);
        checks++;
        if (dmem.dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL %s start: req=%b expected 1", name, dmem.dmem_req);
        end
        k = 0; total = 0; dones = 0;
        while (dmem.dmem_req === 1'b1 && total < 3 * TO) begin
            total++;
            if (k < f) begin
                i_flush_en = 1'b0; dmem.dmem_ack = 1'b0;
            end else if (k == f) begin
                i_flush_en = 1'b1; dmem.dmem_ack = (a == -1); i_load_flag = 1'b0;
            end else begin
                i_flush_en = 1'b0; dmem.dmem_ack = ((k - f - 1) == a);
            end
            dmem.dmem_rdata = W'($urandom());
            @(negedge clk);
            if (o_mem_in_done === 1'b1 || o_mem_err === 1'b1) dones++;
            k++;
        end
        i_flush_en = 1'b0;
        dmem.dmem_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (o_mem_in_done === 1'b1 || o_mem_err === 1'b1) dones++;
        end
        exp_total = (a == -1) ? f + 1 : (a == -2) ? TO : f + a + 2;
        checks++;
        if (total != exp_total) begin
            failures++;
            $display("FAIL %s req_cycles: got %0d expected %0d", name, total, exp_total);
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL %s no_done: got %0d done/err pulses expected 0", name, dones);
        end
        checks++;
        if ({dmem.dmem_req, o_load_data} !== {1'b0, prev}) begin
            failures++;
            $display("FAIL %s after: req=%b load_data=%h expected 0 %h",
                     name, dmem.dmem_req, o_load_data, prev);
        end
    endtask

    task automatic test_flush_idle();
        i_flush_en  = 1'b1;
        i_load_flag = 1'b1;
        i_mem_addr  = 32'h0000_0100;
        i_mem_data  = 32'h0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({dmem.dmem_req, o_mem_in_done} !== 2'b00) begin
                failures++;
                $display("FAIL flush_idle: req=%b done=%b expected 00",
                         dmem.dmem_req, o_mem_in_done);
            end
        end
        i_flush_en = 1'b0;
        run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h5A5A_0001, 1, 1'b1, "after_flush_idle");
    endtask

    task automatic test_reset_mid_req();
        i_load_flag  = 1'b1;
        i_store_flag = 1'b0;
        i_mem_addr   = 32'hCAFE_0010;
        i_mem_data   = 32'h1111_2222;
        dmem.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dmem.dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid pre: req=%b expected 1", dmem.dmem_req);
        end
        #2 rst = 1'b1;
        #1;
        exp_load_data = '0;
        checks++;
        if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata,
             o_mem_in_done, o_mem_err, o_load_data} !== '0) begin
            failures++;
            $display("FAIL rst_mid async: req=%b addr=%h wdata=%h ld=%h expected all 0",
                     dmem.dmem_req, dmem.dmem_addr, dmem.dmem_wdata, o_load_data);
        end
        i_load_flag = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1, 32'h0BAD_F00D, 1, 1'b1, "rst_restart");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] d;
        int r;
        for (int i = 0; i < 5; i++) begin
            r = $urandom_range(1, 3);
            a = W'($urandom());
            d = W'($urandom());
            run_access(r[0], r[1], a, d, 0, W'($urandom()), (i == 0) ? 1 : 2, (i == 4),
                       "back_to_back");
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(1, 3);
            run_access(r[0], r[1], W'($urandom()), W'($urandom()), $urandom_range(0, 19),
                       W'($urandom()), 1, 1'b1, "random");
        end
        for (int i = 0; i < 4; i++) begin
            test_flush($urandom_range(0, 3), int'($urandom_range(0, 5)) - 2, "random_flush");
        end
    endtask

    initial begin
        test_reset();
        run_access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1, 32'hDEAD_BEEF, 1, 1'b1, "load_ack2");
        run_access(1'b0, 1'b1, 32'h0000_0040, 32'h0000_1234, 0, 32'h0, 1, 1'b1, "store_ack1");
        test_flush(1, 2, "flush_drain");
        test_flush(0, -1, "flush_with_ack");
        test_flush(2, -2, "drain_timeout");
        run_access(1'b1, 1'b0, 32'h0000_00C0, 32'h0, 1000, 32'h0, 1, 1'b1, "load_timeout");
        run_access(1'b1, 1'b0, 32'h0000_00C4, 32'h0, 2, 32'h1357_9BDF, 1, 1'b1, "load_refill");
        run_access(1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 0, 32'hFFFF_FFFF, 1, 1'b1,
                   "both_flags");
        test_flush_idle();
        test_back_to_back();
        test_random();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
